// File: rtl/boot_loader.sv
// Byte-serial program loader: takes a length-prefixed little-endian stream, writes 32-bit words
// to instruction memory and holds the CPU in reset until the image is in. Optional trailing XOR checksum: BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_valid alone is ignored.
  typedef enum logic [2:0] {
    S_HDR_LO = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [15:0] LP_MAX_WORDS = 16'(MAX_WORDS);

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t LP_AFTER_PAYLOAD = S_CSUM;
  logic [7:0] r_csum;
`else
  localparam state_t LP_AFTER_PAYLOAD = S_DONE;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_count;
  logic [15:0]       r_word_cnt;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_asm;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_done;
  logic              r_error;

  logic              w_rx_ready;
  logic              w_accept;
  logic [15:0]       w_hdr_n;
  logic              w_last_word;

  assign w_rx_ready  = (r_state == S_HDR_LO) || (r_state == S_HDR_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_accept    = rx_valid && w_rx_ready;
  assign w_hdr_n     = {rx_data, r_count[7:0]};
  assign w_last_word = ((r_word_cnt + 16'd1) == r_count);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR_LO: begin
        if (w_accept) w_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (w_accept) begin
          if (w_hdr_n > LP_MAX_WORDS) w_next = S_ERR;
          else if (w_hdr_n == 16'd0)  w_next = LP_AFTER_PAYLOAD;
          else                        w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word) w_next = LP_AFTER_PAYLOAD;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
      end
`endif
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_HDR_LO;
      r_count    <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= 1'b0;
      if (r_wr_en) r_wr_addr <= r_wr_addr + ADDR_W'(4);
      if (w_accept) begin
        case (r_state)
          S_HDR_LO: r_count[7:0]  <= rx_data;
          S_HDR_HI: r_count[15:8] <= rx_data;
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_wr_en    <= 1'b1;
              r_wr_data  <= {rx_data, r_asm};
              r_word_cnt <= r_word_cnt + 16'd1;
            end else begin
              r_asm <= {rx_data, r_asm[23:8]};
            end
          end
          default: ;
        endcase
      end
      // Leaving DATA straight for DONE delays done by one cycle so the last write lands first.
      r_done  <= (r_state == S_DONE) || ((w_next == S_DONE) && (r_state != S_DATA));
      r_error <= (w_next == S_ERR);
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset)        r_csum <= '0;
    else if (w_accept) r_csum <= r_csum ^ rx_data;
  end
`endif

  assign rx_ready  = w_rx_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign done      = r_done;
  assign error     = r_error;
  assign cpu_reset = !r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected writes go into a queue, a negedge monitor pops and
// compares on each wr_en; status outputs are checked at fixed points after each stream.
module tb_boot_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  logic [95:0] exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_writes = 0;

  logic [7:0] two_word [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

  boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[95:32]);
        check("wr_data", 64'(wr_data), 64'(e[31:0]));
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_state",     64'(dbg_state), 64'd0);
    check("rst_rx_ready",  64'(rx_ready),  64'd1);
    check("rst_wr_en",     64'(wr_en),     64'd0);
    check("rst_wr_addr",   wr_addr,        64'd0);
    check("rst_wr_data",   64'(wr_data),   64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done",      64'(done),      64'd0);
    check("rst_error",     64'(error),     64'd0);
  endtask

  task automatic push_two_word();
    exp_q.push_back({64'h0, 32'h00A00513});
    exp_q.push_back({64'h4, 32'h00100593});
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset();
    check_reset_values();

`ifndef BOOT_LOADER_CHECKSUM_EN
    // two-word load, back to back
    n_writes = 0;
    push_two_word();
    for (int i = 0; i < 10; i++) send_byte(two_word[i]);
    @(negedge clk);
    check("last_wr_en",        64'(wr_en),     64'd1);
    check("last_done_low",     64'(done),      64'd0);
    check("last_cpu_rst_high", 64'(cpu_reset), 64'd1);
    @(negedge clk);
    check("tw_done",      64'(done),      64'd1);
    check("tw_cpu_reset", 64'(cpu_reset), 64'd0);
    check("tw_rx_ready",  64'(rx_ready),  64'd0);
    check("tw_error",     64'(error),     64'd0);
    check("tw_addr_next", wr_addr,        64'd8);
    check("tw_writes",    64'(n_writes),  64'd2);

    // zero count
    do_reset();
    check_reset_values();
    n_writes = 0;
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("zc_done",      64'(done),      64'd1);
    check("zc_cpu_reset", 64'(cpu_reset), 64'd0);
    check("zc_rx_ready",  64'(rx_ready),  64'd0);
    check("zc_writes",    64'(n_writes),  64'd0);

    // oversize count, later bytes ignored
    do_reset();
    n_writes = 0;
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    check("ov_error",     64'(error),     64'd1);
    check("ov_cpu_reset", 64'(cpu_reset), 64'd1);
    check("ov_done",      64'(done),      64'd0);
    check("ov_rx_ready",  64'(rx_ready),  64'd0);
    for (int i = 0; i < 6; i++) send_byte(two_word[i + 2]);
    @(negedge clk);
    check("ov_error_sticky", 64'(error),     64'd1);
    check("ov_state",        64'(dbg_state), 64'd5);
    check("ov_writes",       64'(n_writes),  64'd0);

    // N = MAX_WORDS is accepted
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    @(negedge clk);
    check("max_error",    64'(error),     64'd0);
    check("max_state",    64'(dbg_state), 64'd2);
    check("max_rx_ready", 64'(rx_ready),  64'd1);

    // two-word load with a stall between every byte
    do_reset();
    n_writes = 0;
    push_two_word();
    for (int i = 0; i < 10; i++) begin
      send_byte(two_word[i]);
      if (i < 9) idle();
    end
    @(negedge clk);
    check("st_last_wr_en", 64'(wr_en), 64'd1);
    check("st_done_low",   64'(done),  64'd0);
    @(negedge clk);
    check("st_done",      64'(done),      64'd1);
    check("st_cpu_reset", 64'(cpu_reset), 64'd0);
    check("st_addr_next", wr_addr,        64'd8);
    check("st_writes",    64'(n_writes),  64'd2);

    // reset after five bytes, then the full stream
    do_reset();
    n_writes = 0;
    for (int i = 0; i < 5; i++) send_byte(two_word[i]);
    do_reset();
    check_reset_values();
    push_two_word();
    for (int i = 0; i < 10; i++) send_byte(two_word[i]);
    repeat (2) @(negedge clk);
    check("mr_done",   64'(done),     64'd1);
    check("mr_writes", 64'(n_writes), 64'd2);
`else
    // checksum matches
    n_writes = 0;
    exp_q.push_back({64'h0, 32'h44332211});
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h45);
    @(negedge clk);
    check("cs_done",      64'(done),      64'd1);
    check("cs_error",     64'(error),     64'd0);
    check("cs_cpu_reset", 64'(cpu_reset), 64'd0);
    check("cs_writes",    64'(n_writes),  64'd1);

    // checksum mismatch: write stays, load aborts
    do_reset();
    check_reset_values();
    n_writes = 0;
    exp_q.push_back({64'h0, 32'h44332211});
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h46);
    @(negedge clk);
    check("cb_error",     64'(error),     64'd1);
    check("cb_done",      64'(done),      64'd0);
    check("cb_cpu_reset", 64'(cpu_reset), 64'd1);
    check("cb_writes",    64'(n_writes),  64'd1);

    // zero count takes a checksum byte of 00
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    check("cz_state", 64'(dbg_state), 64'd3);
    send_byte(8'h00);
    @(negedge clk);
    check("cz_done", 64'(done), 64'd1);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-serial program loader sitting directly upstream of the CPU's instruction memory. After reset it accepts a length-prefixed stream of instruction words, assembles them little-endian into 32-bit words and writes them into consecutive instruction-memory locations. It holds the CPU's program counter in reset until the image is loaded, then releases it so execution starts at `BASE_ADDR`.

## Interface
Parameters:
- `ADDR_W`, 64, width of `wr_addr`; matches the PC width.
- `BASE_ADDR`, 0, byte address of the first word written.
- `MAX_WORDS`, 256, largest accepted word count; larger headers go to error.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset, synchronous and active-low.
- `rx_valid` in 1: `rx_data` holds a byte.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader can take a byte; a byte transfers when `rx_valid && rx_ready` at a rising edge.
- `wr_en` out 1: instruction-memory write strobe, one cycle per word.
- `wr_addr` out ADDR_W: byte address of the word being written.
- `wr_data` out 32: assembled instruction word.
- `cpu_reset` out 1: active-high reset to the PC; high until the load completes.
- `done` out 1: image loaded; sticky.
- `error` out 1: load aborted; sticky.

## Operation
- States: `HDR_LO` → `HDR_HI` → `DATA` → (`CSUM`) → `DONE`; any state can go to `ERR`.
- `HDR_LO` / `HDR_HI`: take the low byte, then the high byte, of a 16-bit word count N.
- After `HDR_HI`:
  - N > `MAX_WORDS` → `ERR`.
  - N = 0 → `CSUM` if checksum is enabled, otherwise `DONE`.
  - Otherwise → `DATA`.
- `DATA`:
  - Byte counter 0..3; byte k goes to `wr_data[8k+7:8k]`.
  - On the 4th byte, a write is issued and the word counter increments.
  - After word N, move on as for N = 0.
- Address:
  - First write uses `BASE_ADDR`; each later write adds 4.
  - Addition wraps modulo 2^ADDR_W and has no error.
- `rx_ready` is 1 in `HDR_LO`, `HDR_HI`, `DATA` and `CSUM`, and 0 in `DONE` and `ERR`.
- `DONE` and `ERR` are terminal. Only `reset` leaves them.
- `rx_valid` while `rx_ready` = 0 is ignored.
- Reset mid-load:
  - All state and counters clear and the load restarts at `HDR_LO`.
  - Words already written stay in memory and are not erased.

## Timing
- Reset values (the cycle after `reset` is sampled low):
  - state `HDR_LO`
  - `rx_ready` = 1
  - `wr_en` = 0, `wr_addr` = `BASE_ADDR`, `wr_data` = 0
  - `cpu_reset` = 1, `done` = 0, `error` = 0
- Write latency: `wr_en`, `wr_addr` and `wr_data` are registered. `wr_en` is high for exactly the one cycle after the edge that accepts a word's 4th byte.
- `wr_addr` increments in the cycle after the `wr_en` pulse.
- Throughput: one byte per cycle, with no bubbles across word boundaries.
- Gaps in `rx_valid` stall the loader without losing state.
- `done` rises and `cpu_reset` falls on the same edge. For the last payload word, that is the edge after the `wr_en` cycle, so the final write always lands before the CPU leaves reset.
  - Checksum disabled, N = 0: `done` rises on the edge after `HDR_HI` is accepted.
  - Checksum enabled: `done` rises on the edge after the checksum byte is accepted.
- `error` rises on the edge after the offending byte is accepted.
- In `ERR`: `cpu_reset` stays 1 and `done` stays 0.

## Configuration
- `BOOT_LOADER_CHECKSUM_EN` defined:
  - After the payload (or after the header when N = 0), the loader takes one extra byte in state `CSUM`.
  - The running checksum is the XOR of all bytes received, header bytes included, and is cleared on reset.
  - Received byte equals the running checksum → `DONE`. Otherwise → `ERR`.
  - Words already written are not rolled back.
- `BOOT_LOADER_CHECKSUM_EN` undefined:
  - The `CSUM` state and the checksum register are not built.
  - The load completes directly after the payload.

## Test plan
- **Two-word load** (checksum off): stream 02 00 13 05 A0 00 93 05 10 00 →
  - `wr_en` pulses twice.
  - First write: `wr_addr` = 0, `wr_data` = 0x00A00513.
  - Second write: `wr_addr` = 4, `wr_data` = 0x00100593.
  - Then `done` = 1, `cpu_reset` = 0 and `rx_ready` = 0.
- **Zero count**: stream 00 00 → no `wr_en`; `done` = 1 one cycle after the second byte (checksum off).
- **Oversize count**: stream 01 01 (N = 257 > 256) → `error` = 1, `cpu_reset` = 1, no writes; later bytes are ignored.
- **Checksum** (`BOOT_LOADER_CHECKSUM_EN`): stream 01 00 11 22 33 44 45 → `done` = 1. The same stream ending in 46 instead → `error` = 1 after one write of 0x44332211.
- **Stalls**: the two-word stream with `rx_valid` low on alternate cycles → identical writes and final state, only later.
- **Reset mid-load**: assert `reset` low after 5 bytes of the two-word stream, then send the full stream → exactly two `wr_en` pulses, at addresses 0 and 4, then `done` = 1.
